// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: multi-cycle adder that walks one 2-bit ripple slice
// across WIDTH-bit operands, LSB slice first, with a start/done handshake.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the signed-overflow
// output ovf.

// Single-bit full adder; two of these chained form the 2-bit slice.
module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_OVF_EN
  output logic             ovf,
`endif
  output logic             cout
);
  localparam int N    = WIDTH / 2;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state;
  logic [IDXW-1:0]     idx;
  logic                carry;
  logic [N-1:0][1:0]   a_r, b_r, sum_r;

  // Current slice operands and the internal ripple carries c[0..2].
  logic [1:0] a_sl, b_sl, s_sl;
  logic [2:0] c;

  assign a_sl = a_r[idx];
  assign b_sl = b_r[idx];
  assign c[0] = carry;

  // Two full adders rippling within the slice.
  for (genvar i = 0; i < 2; i++) begin : g_fa
    serial_adder_fa u_fa (
      .a  (a_sl[i]),
      .b  (b_sl[i]),
      .ci (c[i]),
      .s  (s_sl[i]),
      .co (c[i+1])
    );
  end

  assign sum = sum_r;

  // Control FSM plus datapath registers; all outputs are registered here.
  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      state <= IDLE;
      idx   <= '0;
      carry <= 1'b0;
      a_r   <= '0;
      b_r   <= '0;
      sum_r <= '0;
      cout  <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_r   <= a;
            b_r   <= b;
            carry <= cin;
            idx   <= '0;
            sum_r <= '0;
            busy  <= 1'b1;
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= 1'b0;
`endif
            state <= RUN;
          end
        end
        RUN: begin
          sum_r[idx] <= s_sl;
          carry      <= c[2];
          if (idx == IDX_LAST) begin
            // Last slice: publish carry-out and raise done for one cycle.
            cout  <= c[2];
`ifdef SERIAL_ADDER_OVF_EN
            ovf   <= c[1] ^ c[2];
`endif
            idx   <= '0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/serial_adder_ctrl.md
Name: serial_adder_ctrl

Overview:
- Multi-cycle adder controller: sequences one 2-bit ripple slice (two full adders plus a carry register) across WIDTH-bit operands, 2 bits per cycle, LSB slice first.
- Trades area for latency. Owns operand capture, slice indexing, inter-slice carry and result assembly, with a start/done handshake toward the requesting FSM or testbench.

Parameters:
- WIDTH, 8, operand/result width. Must be even and >= 2. Slice count N = WIDTH/2.

Ports:
- clk  input  1  rising-edge clock
- reset_b  input  1  asynchronous active-low reset
- start  input  1  request; sampled only in IDLE
- a  input  WIDTH  operand A; captured on the accepting edge
- b  input  WIDTH  operand B; captured on the accepting edge
- cin  input  1  carry-in; captured on the accepting edge
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse; result valid
- sum  output  WIDTH  registered result
- cout  output  1  registered carry-out of the MSB slice

Behaviour:
- Reset (reset_b=0, asynchronous): state=IDLE, idx=0, carry=0, sum=0, cout=0, busy=0, done=0. Holds while reset_b=0. Takes effect immediately, including mid-RUN. The partial result is discarded; no done is issued.
- States:
  - IDLE: busy=0, done=0. start=1 at an edge -> capture a, b, cin into internal regs; carry<=cin; idx<=0; sum<=0; go to RUN.
  - RUN: busy=1. Each edge: {c, s[1:0]} = a_r[2idx+1:2idx] + b_r[2idx+1:2idx] + carry. sum[2idx+1:2idx]<=s; carry<=c; idx<=idx+1.
  - RUN exit: on the edge processing idx==N-1, cout<=c, go to DONE.
  - DONE: busy=1, done=1 for exactly one cycle. Next edge -> IDLE.
- Full-adder slice equations are exact: s=a^b^c; co=ab|ac|bc. Slice bit 1 uses the carry out of slice bit 0.
- Latency: start sampled at edge E0. done is high during the cycle following edge E0+N. For WIDTH=8, done follows edge E0+4. Throughput is one add per N+2 cycles.
- sum and cout hold their value after DONE until the next accepted start or reset.
- sum updates slice by slice during RUN. It is valid only when done=1 or afterwards in IDLE.
- start in RUN or DONE is ignored, not queued. a, b and cin may change freely after the accepting edge.
- start held high continuously: a new operation is accepted on the first IDLE edge (after DONE).
- WIDTH=2: a single RUN cycle, then DONE.
- idx width is clog2(N), minimum 1. idx never exceeds N-1.

Optional Feature:
- Macro: SERIAL_ADDER_OVF_EN.
- Defined:
  - Adds output port ovf (output, 1 bit), reset 0.
  - On the final RUN edge: ovf <= carry-into-MSB XOR carry-out-of-MSB, i.e. two's-complement signed overflow.
  - Cleared to 0 on an accepted start. Holds like sum.
- Undefined: port absent; no overflow logic.

Test Plan (WIDTH=8):
- Basic add: reset_b low 2 cycles then high; start with a=8'h0F, b=8'h01, cin=0 -> busy next cycle; done after edge E0+4 with sum=8'h10, cout=0; idle after.
- Carry chain and equation check:
  - a=8'h00, b=8'h01, cin=1 -> sum=8'h02, cout=0. Catches slice sum-equation errors.
  - a=8'hAA, b=8'h55, cin=1 -> sum=8'h00, cout=1.
- Wrap-around: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. With SERIAL_ADDER_OVF_EN -> ovf=0. Then a=8'h7F, b=8'h01 -> sum=8'h80, cout=0, ovf=1.
- Busy ignore: start a=8'h10, b=8'h20; pulse start with a=8'hFF, b=8'hFF at E0+2 -> sum=8'h30, exactly one done pulse; no second operation starts.
- Reset mid-operation: start a=8'h33, b=8'h44; assert reset_b at E0+2 between edges -> sum, cout, busy, done all 0 immediately, no done. Release, then start a=8'h01, b=8'h02 -> sum=8'h03.
- Back-to-back: hold start=1 with a=8'h05, b=8'h06 -> done pulses every 6 cycles, each with sum=8'h0B.
